wb_cmd_initiator: RTL and testbench



---
 rtl/wb_cmd_initiator_pkg.sv | 20 ++
 rtl/wb_cmd_tmo.sv | 27 ++
 rtl/wb_cmd_initiator.sv | 156 +++++++++++++++
 tb/tb_wb_cmd_initiator.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_cmd_initiator_pkg.sv
// Shared definitions for the byte-command Wishbone initiator: FSM states,
// response status codes and CMD byte layout.
package wb_cmd_initiator_pkg;

  typedef enum logic [2:0] {
    ST_CMD   = 3'd0,
    ST_ADDR  = 3'd1,
    ST_WDATA = 3'd2,
    ST_BUS   = 3'd3,
    ST_RSTAT = 3'd4,
    ST_RDATA = 3'd5
  } state_e;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;
  localparam logic [7:0] ST_BADCMD  = 8'h02;

  localparam int CMD_WE_BIT = 7;

endpackage

// File: rtl/wb_cmd_tmo.sv
// Ack-timeout counter: cleared while idle, counts every bus-wait cycle and
// flags expiry at all-ones (holds there until cleared).
module wb_cmd_tmo #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = &cnt_q;

endmodule

// File: rtl/wb_cmd_initiator.sv
// Byte-stream to single 32-bit Wishbone cycle initiator with status/read-data response stream.
// Optional ack timeout enabled by defining WB_CMD_INITIATOR_TIMEOUT_EN.
module wb_cmd_initiator
  import wb_cmd_initiator_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [31:0]       wb_wdata,
  input  logic [31:0]       wb_rdata,
  output logic              wb_we,
  output logic              wb_cyc,
  input  logic              wb_ack
);

  state_e            state_q;
  logic [1:0]        idx_q;
  logic [1:0]        idx_nx;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              cyc_q;
  logic [7:0]        status_q;
  logic [7:0]        out_data_q;
  logic              out_valid_q;
  logic              in_hs;
  logic              out_hs;
  logic              tmo_expired;

  assign in_ready = rst_n & ((state_q == ST_CMD) | (state_q == ST_ADDR) | (state_q == ST_WDATA));
  assign in_hs    = in_valid & in_ready;
  assign out_hs   = out_valid_q & out_ready;
  assign idx_nx   = idx_q + 2'd1;

`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
  wb_cmd_tmo #(
    .W(TIMEOUT_W)
  ) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (state_q != ST_BUS),
    .en_i     (state_q == ST_BUS),
    .expired_o(tmo_expired)
  );
`else
  logic [TIMEOUT_W-1:0] tmo_unused;
  assign tmo_unused  = '0;
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CMD;
      idx_q       <= 2'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cyc_q       <= 1'b0;
      status_q    <= ST_OK;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (in_hs) begin
            if (in_data[6:0] != 7'd0) begin
              status_q    <= ST_BADCMD;
              out_data_q  <= ST_BADCMD;
              out_valid_q <= 1'b1;
              state_q     <= ST_RSTAT;
            end else begin
              we_q    <= in_data[CMD_WE_BIT];
              state_q <= ST_ADDR;
            end
          end
        end
        ST_ADDR: begin
          if (in_hs) begin
            addr_q  <= ADDR_W'(in_data);
            idx_q   <= 2'd0;
            state_q <= we_q ? ST_WDATA : ST_BUS;
          end
        end
        ST_WDATA: begin
          if (in_hs) begin
            wdata_q[{idx_q, 3'b000} +: 8] <= in_data;
            idx_q <= idx_nx;
            if (idx_q == 2'd3) state_q <= ST_BUS;
          end
        end
        ST_BUS: begin
          // Ack is checked before expiry so a last-moment ack still reports OK.
          if (!cyc_q) begin
            cyc_q <= 1'b1;
          end else if (wb_ack) begin
            cyc_q       <= 1'b0;
            rdata_q     <= wb_rdata;
            status_q    <= ST_OK;
            out_data_q  <= ST_OK;
            out_valid_q <= 1'b1;
            state_q     <= ST_RSTAT;
          end else if (tmo_expired) begin
            cyc_q       <= 1'b0;
            status_q    <= ST_TIMEOUT;
            out_data_q  <= ST_TIMEOUT;
            out_valid_q <= 1'b1;
            state_q     <= ST_RSTAT;
          end
        end
        ST_RSTAT: begin
          if (out_hs) begin
            if (!we_q && status_q == ST_OK) begin
              out_data_q <= rdata_q[7:0];
              idx_q      <= 2'd0;
              state_q    <= ST_RDATA;
            end else begin
              out_valid_q <= 1'b0;
              state_q     <= ST_CMD;
            end
          end
        end
        ST_RDATA: begin
          if (out_hs) begin
            if (idx_q == 2'd3) begin
              out_valid_q <= 1'b0;
              state_q     <= ST_CMD;
            end else begin
              out_data_q <= rdata_q[{idx_nx, 3'b000} +: 8];
              idx_q      <= idx_nx;
            end
          end
        end
        default: state_q <= ST_CMD;
      endcase
    end
  end

  assign wb_cyc    = cyc_q;
  assign wb_we     = we_q;
  assign wb_addr   = addr_q;
  assign wb_wdata  = wdata_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Randomized bench for wb_cmd_initiator: frame-level reference model, toggling-ack slave,
// random response backpressure, timeout/stuck-bus and mid-cycle reset scenarios.
module tb_wb_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_ack = 1'b0;

  always #5 clk = ~clk;

  wb_cmd_initiator #(
    .TIMEOUT_W(4),
    .ADDR_W   (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .wb_addr  (wb_addr),
    .wb_wdata (wb_wdata),
    .wb_rdata (wb_rdata),
    .wb_we    (wb_we),
    .wb_cyc   (wb_cyc),
    .wb_ack   (wb_ack)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Peripheral-style slave: registered single-cycle ack, data only in the ack cycle.
  logic [31:0] regs[256];
  bit          written[256];
  bit          slave_en = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack <= 1'b0;
    end else begin
      wb_ack <= wb_cyc & ~wb_ack & slave_en;
      if (wb_cyc && wb_ack && wb_we) begin
        regs[wb_addr]    <= wb_wdata;
        written[wb_addr] <= 1'b1;
      end
    end
  end

  assign wb_rdata = wb_ack ? (written[wb_addr] ? regs[wb_addr] : init_val(wb_addr)) : 32'h0;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // Bus monitor
  int          n_rise, n_ack, rise_at, ack_at, cyc_hi;
  logic        ack_we;
  logic [7:0]  ack_addr;
  logic [31:0] ack_wdata;
  logic        p_ack, p_cyc, p_we;
  logic [7:0]  p_addr;
  logic [31:0] p_wdata;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ack = 1'b0;
      p_cyc = 1'b0;
    end else begin
      if (p_ack) chk("cyc_after_ack", wb_cyc, 0);
      if (p_cyc && wb_cyc) begin
        chk("bus_stable", {wb_we, wb_addr}, {p_we, p_addr});
        chk("wdata_stable", wb_wdata, p_wdata);
      end
      if (wb_cyc && !p_cyc) begin n_rise++; rise_at = cyc_cnt; end
      if (wb_cyc) cyc_hi++;
      if (wb_ack) begin
        n_ack++;
        ack_at    = cyc_cnt;
        ack_we    = wb_we;
        ack_addr  = wb_addr;
        ack_wdata = wb_wdata;
      end
      p_ack = wb_ack; p_cyc = wb_cyc; p_we = wb_we; p_addr = wb_addr; p_wdata = wb_wdata;
    end
  end

  // Response sink with random and forced backpressure
  logic [7:0] rx_q[$];
  int         rx_total = 0;
  int         bp_at = -1;
  int         bp_hold = 0;
  logic       pv, pr;
  logic [7:0] pd;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
      end else begin
        if (pv && !pr) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, pd);
        end
        if (bp_at >= 0 && rx_total == bp_at && out_valid) begin
          bp_hold = 10;
          bp_at   = -1;
        end
        if (bp_hold > 0) begin
          out_ready = 1'b0;
          bp_hold--;
        end else begin
          out_ready = ($urandom % 4) != 0;
        end
        if (out_valid && out_ready) begin
          rx_q.push_back(out_data);
          rx_total++;
        end
        pv = out_valid; pr = out_ready; pd = out_data;
      end
    end
  end

  logic [31:0] ref_mem[256];
  int          last_acc;

  // Called and returns at a negedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (!in_ready) begin
      chk("in_ready_wait", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    last_acc = cyc_cnt;
    in_valid = 1'b0;
    repeat ($urandom % 3) @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [31:0] d);
    logic [7:0] exp[$];
    bit         bus;
    int         n;
    bus = (cmd[6:0] == 7'd0);
    if (!bus) begin
      exp.push_back(8'h02);
    end else if (cmd[7]) begin
      ref_mem[addr] = d;
      exp.push_back(8'h00);
    end else begin
      exp.push_back(8'h00);
      for (int i = 0; i < 4; i++) exp.push_back(8'((ref_mem[addr] >> (8 * i))));
    end
    n_rise = 0; n_ack = 0; cyc_hi = 0;
    rx_q.delete();
    send_byte(cmd);
    if (bus) begin
      send_byte(addr);
      if (cmd[7]) for (int i = 0; i < 4; i++) send_byte(8'((d >> (8 * i))));
    end
    n = 0;
    while (rx_q.size() < exp.size() && n < 400) begin @(negedge clk); n++; end
    repeat (6) @(negedge clk);
    chk("resp_len", rx_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) chk("resp_byte", rx_q[i], exp[i]);
    chk("n_cyc", n_rise, bus);
    chk("n_ack", n_ack, bus);
    if (bus) begin
      chk("cyc_lat", rise_at - last_acc, 1);
      chk("ack_lat", ack_at - rise_at, 1);
      chk("ack_we", ack_we, cmd[7]);
      chk("ack_addr", ack_addr, addr);
      if (cmd[7]) chk("ack_wdata", ack_wdata, d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [7:0]  cmd, a;
    logic [31:0] d;
    int          r, n;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));

    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_addr", wb_addr, 0);
    chk("rst_wdata", wb_wdata, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_odata", out_data, 0);
    chk("rst_iready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("iready_after_rst", in_ready, 1);

    do_frame(8'h80, 8'h05, 32'hDEADBEEF);
    do_frame(8'h00, 8'h05, 32'h0);
    do_frame(8'h41, 8'h00, 32'h0);
    do_frame(8'h00, 8'h05, 32'h0);
    bp_at = rx_total + 2;
    do_frame(8'h00, 8'h05, 32'h0);
    chk("bp_applied", bp_at, -1);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      a = 8'($urandom_range(0, 15));
      d = $urandom;
      if (r < 4) cmd = 8'h80;
      else if (r < 8) cmd = 8'h00;
      else begin
        cmd = 8'($urandom_range(1, 255));
        if (cmd[6:0] == 7'd0) cmd = cmd | 8'h01;
      end
      do_frame(cmd, a, d);
    end

    // Silent slave
    slave_en = 1'b0;
    n_rise = 0; cyc_hi = 0;
    rx_q.delete();
    send_byte(8'h00);
    send_byte(8'h07);
`ifdef WB_CMD_INITIATOR_TIMEOUT_EN
    n = 0;
    while (rx_q.size() < 1 && n < 200) begin @(negedge clk); n++; end
    repeat (8) @(negedge clk);
    chk("tmo_cyc_cycles", cyc_hi, 15);
    chk("tmo_len", rx_q.size(), 1);
    chk("tmo_status", rx_q.size() > 0 ? rx_q[0] : 8'hFF, 8'h01);
    send_byte(8'h00);
    send_byte(8'h07);
    n = 0;
    while (!wb_cyc && n < 10) begin @(negedge clk); n++; end
`else
    repeat (1000) @(negedge clk);
    chk("cyc_stuck", wb_cyc, 1);
    chk("stuck_no_resp", rx_q.size(), 0);
`endif
    chk("cyc_before_rst", wb_cyc, 1);

    // Mid-cycle reset
    rst_n = 1'b0;
    #1;
    chk("rst_async_cyc", wb_cyc, 0);
    chk("rst_async_iready", in_ready, 0);
    chk("rst_async_ovalid", out_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    slave_en = 1'b1;
    rx_q.delete();
    @(negedge clk);
    chk("iready_after_abort", in_ready, 1);
    repeat (20) @(negedge clk);
    chk("no_stale_resp", rx_q.size(), 0);
    do_frame(8'h80, 8'h09, 32'h12345678);
    do_frame(8'h00, 8'h09, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
